cache_axi_rd_arbiter: RTL and testbench

//  Sequences cache line refills for the instruction and data caches over one shared AXI read port.
//  It arbitrates between the two requesters and issues one 4-beat INCR burst of 32-bit beats per refill.
//  It packs the beats into a 128-bit line and returns the line to the winner with a one-cycle ret_valid pulse.

---
 rtl/cache_axi_rd_arbiter.sv | 147 ++++++++++++++
 tb/tb_cache_axi_rd_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_rd_arbiter.sv
// Cache refill arbiter: icache/dcache miss requests share one AXI read port.
// Each refill is one 4-beat INCR burst of 32-bit beats packed into a 128-bit line.
// Ports:
//   clk, resetn (sync, active-low)
//   ic_rd_req/addr/rdy, ic_ret_valid/data : icache miss interface
//   dc_rd_req/addr/rdy, dc_ret_valid/data : dcache miss interface
//   arid/araddr/arlen/arsize/arburst/arvalid/arready : AXI AR channel
//   rdata/rlast/rvalid/rready : AXI R channel
// Build option: define RR_ARB_EN for round-robin arbitration on ties;
// otherwise the dcache has fixed priority.
module cache_axi_rd_arbiter #(
    parameter logic [3:0] IC_ARID = 4'd0,
    parameter logic [3:0] DC_ARID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ic_rd_req,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic [127:0] ic_ret_data,
    input  logic         dc_rd_req,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic [127:0] dc_ret_data,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RET  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [1:0]     cnt;
    logic [127:0]   line;
    logic [127:0]   line_nxt;
    logic           grant_dc;
    logic           last_dc;
    logic           pick_dc;
    logic           accept;
    logic           beat;

    // Line offset bits are irrelevant: refills are always line-aligned.
    logic unused_offs;
    assign unused_offs = ^{ic_rd_addr[3:0], dc_rd_addr[3:0]};

    assign arlen   = 8'd3;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;

    assign accept = (state == IDLE) && (ic_rd_req || dc_rd_req);
    assign beat   = (state == R) && rvalid;

    // Winner selection when in IDLE; a lone requester always wins.
`ifdef RR_ARB_EN
    assign pick_dc = dc_rd_req && (!ic_rd_req || !last_dc);
`else
    assign pick_dc = dc_rd_req;
`endif

    // Current line with the incoming beat merged into word cnt.
    always_comb begin
        line_nxt = line;
        line_nxt[{cnt, 5'b0} +: 32] = rdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = AR;
            AR:   if (arready) state_nxt = R;
            R:    if (rvalid && rlast) state_nxt = RET;
            RET:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ic_rd_rdy    = (state == IDLE);
        dc_rd_rdy    = (state == IDLE);
        arvalid      = (state == AR);
        rready       = (state == R);
        ic_ret_valid = (state == RET) && !grant_dc;
        dc_ret_valid = (state == RET) && grant_dc;
    end

    // Datapath: request latch, beat packing, return registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt         <= 2'd0;
            line        <= '0;
            araddr      <= '0;
            arid        <= '0;
            grant_dc    <= 1'b0;
            last_dc     <= 1'b0;
            ic_ret_data <= '0;
            dc_ret_data <= '0;
        end else begin
            if (accept) begin
                grant_dc <= pick_dc;
                arid     <= pick_dc ? DC_ARID : IC_ARID;
                araddr   <= pick_dc ? {dc_rd_addr[31:4], 4'b0}
                                    : {ic_rd_addr[31:4], 4'b0};
            end
            if (beat) begin
                line <= line_nxt;
                cnt  <= cnt + 2'd1;
                // Capture the finished line so it is on ret_data during RET.
                if (rlast) begin
                    if (grant_dc) dc_ret_data <= line_nxt;
                    else          ic_ret_data <= line_nxt;
                end
            end
            if (state == RET) begin
                last_dc <= grant_dc;
                cnt     <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Testbench for cache_axi_rd_arbiter: directed refills checked against a
// transaction-level model every cycle, plus hand-computed literal checks.
module tb_cache_axi_rd_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ic_rd_req, dc_rd_req;
    logic [31:0]  ic_rd_addr, dc_rd_addr;
    logic         ic_rd_rdy, dc_rd_rdy;
    logic         ic_ret_valid, dc_ret_valid;
    logic [127:0] ic_ret_data, dc_ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic         rlast, rvalid, rready;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cache_axi_rd_arbiter dut (
        .clk(clk), .resetn(resetn),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A refill is: wait for the address handshake, collect beats until
    // rlast, then announce the line for one cycle.
    bit           m_ok = 0;
    bit           m_wait_ar, m_collect, m_announce;
    bit           m_to_dc, m_last_dc;
    int           m_beats;
    logic [127:0] m_line, m_ic_line, m_dc_line;
    logic [31:0]  m_addr;
    logic [3:0]   m_id;

    always @(posedge clk) begin : model
        logic [127:0] tmp;
        bit           want_dc;
        m_ok <= 1;
        if (!resetn) begin
            m_wait_ar <= 0; m_collect <= 0; m_announce <= 0;
            m_to_dc <= 0; m_last_dc <= 0; m_beats <= 0;
            m_line <= '0; m_ic_line <= '0; m_dc_line <= '0;
            m_addr <= '0; m_id <= '0;
        end else if (m_announce) begin
            m_announce <= 0;
            m_last_dc  <= m_to_dc;
            m_beats    <= 0;
        end else if (m_collect) begin
            if (rvalid) begin
                tmp = m_line;
                tmp[(m_beats % 4) * 32 +: 32] = rdata;
                m_line  <= tmp;
                m_beats <= m_beats + 1;
                if (rlast) begin
                    m_collect  <= 0;
                    m_announce <= 1;
                    if (m_to_dc) m_dc_line <= tmp;
                    else         m_ic_line <= tmp;
                end
            end
        end else if (m_wait_ar) begin
            if (arready) begin
                m_wait_ar <= 0;
                m_collect <= 1;
            end
        end else if (ic_rd_req || dc_rd_req) begin
`ifdef RR_ARB_EN
            want_dc = (ic_rd_req && dc_rd_req) ? !m_last_dc : dc_rd_req;
`else
            want_dc = dc_rd_req;
`endif
            m_to_dc   <= want_dc;
            m_id      <= want_dc ? 4'd1 : 4'd0;
            m_addr    <= (want_dc ? dc_rd_addr : ic_rd_addr) & 32'hFFFF_FFF0;
            m_wait_ar <= 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            automatic bit idle = !(m_wait_ar || m_collect || m_announce);
            chk("ic_rd_rdy", ic_rd_rdy, idle);
            chk("dc_rd_rdy", dc_rd_rdy, idle);
            chk("arvalid", arvalid, m_wait_ar);
            chk("rready", rready, m_collect);
            chk("ic_ret_valid", ic_ret_valid, m_announce && !m_to_dc);
            chk("dc_ret_valid", dc_ret_valid, m_announce && m_to_dc);
            chk("ic_ret_data", ic_ret_data, m_ic_line);
            chk("dc_ret_data", dc_ret_data, m_dc_line);
            chk("araddr", araddr, m_addr);
            chk("arid", arid, m_id);
            chk("arlen", arlen, 8'd3);
            chk("arsize", arsize, 3'd2);
            chk("arburst", arburst, 2'b01);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_wait(input int stall);
        int n = 0;
        while (!arvalid && n < 20) begin step(); n++; end
        chk("arvalid_wait", arvalid, 1'b1);
        arready = 1'b0;
        repeat (stall) step();
        chk("ar_hold", arvalid, 1'b1);
        arready = 1'b1;
        step();
        arready = 1'b0;
    endtask

    // pat bit i = rvalid in cycle i; sends nb beats, rlast on the 4th.
    task automatic r_burst(input logic [127:0] d, input logic [7:0] pat,
                           input int plen, input int nb);
        int n = 0;
        int k = 0;
        while (!rready && n < 20) begin step(); n++; end
        chk("rready_wait", rready, 1'b1);
        for (int i = 0; i < plen && k < nb; i++) begin
            rvalid = pat[i];
            rdata  = pat[i] ? d[32*k +: 32] : 32'hDEAD_BEEF;
            rlast  = pat[i] && (k == 3);
            step();
            if (pat[i]) k++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic serve(input logic [127:0] d);
        ar_wait(0);
        r_burst(d, 8'hFF, 4, 4);
        step();
    endtask

    localparam logic [127:0] L1 =
        128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] L2 =
        128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    localparam logic [127:0] L3 =
        128'hC3000003_C2000002_C1000001_C0000000;

    initial begin
        resetn = 1'b0;
        ic_rd_req = 0; dc_rd_req = 0;
        ic_rd_addr = '0; dc_rd_addr = '0;
        arready = 0; rdata = '0; rlast = 0; rvalid = 0;
        step(); step();
        resetn = 1'b1;

        // reset state
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_ic_data", ic_ret_data, 128'h0);
        chk("rst_rdy", ic_rd_rdy, 1'b1);

        // 1) icache only
        ic_rd_req = 1; ic_rd_addr = 32'h1FC0_0124;
        step();
        ic_rd_req = 0;
        chk("t1_arvalid", arvalid, 1'b1);
        chk("t1_araddr", araddr, 32'h1FC0_0120);
        chk("t1_arid", arid, 4'd0);
        ar_wait(0);
        r_burst(L1, 8'hFF, 4, 4);
        chk("t1_ret_valid", ic_ret_valid, 1'b1);
        chk("t1_ret_data", ic_ret_data, L1);
        step();
        chk("t1_pulse_end", ic_ret_valid, 1'b0);
        chk("t1_rdy_back", ic_rd_rdy, 1'b1);

        // 2) tie: dcache first, icache next
        ic_rd_req = 1; ic_rd_addr = 32'h0000_1004;
        dc_rd_req = 1; dc_rd_addr = 32'h0000_2000;
        step();
        dc_rd_req = 0;
        chk("t2_arid_dc", arid, 4'd1);
        chk("t2_araddr_dc", araddr, 32'h0000_2000);
        ar_wait(0);
        r_burst(L2, 8'hFF, 4, 4);
        chk("t2_dc_data", dc_ret_data, L2);
        step();
        step();
        ic_rd_req = 0;
        chk("t2_arid_ic", arid, 4'd0);
        chk("t2_araddr_ic", araddr, 32'h0000_1000);
        serve(L3);
        chk("t2_ic_data", ic_ret_data, L3);

        // dcache-only refill, then a second tie
        dc_rd_req = 1; dc_rd_addr = 32'h0000_3008;
        step();
        dc_rd_req = 0;
        serve(L1);
        ic_rd_req = 1; dc_rd_req = 1;
        step();
`ifdef RR_ARB_EN
        chk("t2_tie2_arid", arid, 4'd0);
        ic_rd_req = 0;
`else
        chk("t2_tie2_arid", arid, 4'd1);
        dc_rd_req = 0;
`endif
        serve(L2);
        step();
        ic_rd_req = 0; dc_rd_req = 0;
        serve(L3);

        // 3) AR stall for 3 cycles
        dc_rd_req = 1; dc_rd_addr = 32'h8000_00FC;
        step();
        dc_rd_req = 0;
        ar_wait(3);
        chk("t3_rready", rready, 1'b1);
        r_burst(L1, 8'hFF, 4, 4);
        step();

        // 4) rvalid gaps 1,0,1,0,1,1
        ic_rd_req = 1; ic_rd_addr = 32'h0000_4010;
        step();
        ic_rd_req = 0;
        ar_wait(0);
        r_burst(L3, 8'b0011_0101, 6, 4);
        chk("t4_ret_valid", ic_ret_valid, 1'b1);
        chk("t4_ret_data", ic_ret_data, L3);
        step();

        // 5) reset after beat 2
        ic_rd_req = 1; ic_rd_addr = 32'h0000_5000;
        step();
        ic_rd_req = 0;
        ar_wait(0);
        r_burst(L2, 8'hFF, 2, 2);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("t5_rready", rready, 1'b0);
        chk("t5_no_ret", ic_ret_valid, 1'b0);
        chk("t5_rdy", ic_rd_rdy, 1'b1);
        step();
        chk("t5_no_ret2", ic_ret_valid, 1'b0);
        dc_rd_req = 1; dc_rd_addr = 32'h0000_6000;
        step();
        dc_rd_req = 0;
        ar_wait(0);
        r_burst(L1, 8'hFF, 4, 4);
        chk("t5_new_data", dc_ret_data, L1);
        step();

        // 6) request during R is ignored until IDLE
        dc_rd_req = 1; dc_rd_addr = 32'h0000_7000;
        step();
        dc_rd_req = 0;
        ar_wait(0);
        ic_rd_req = 1; ic_rd_addr = 32'h0000_7100;
        chk("t6_rdy_busy", ic_rd_rdy, 1'b0);
        r_burst(L2, 8'hFF, 4, 4);
        chk("t6_arid_hold", arid, 4'd1);
        step();
        chk("t6_idle_rdy", ic_rd_rdy, 1'b1);
        step();
        ic_rd_req = 0;
        chk("t6_accept", arvalid, 1'b1);
        chk("t6_arid", arid, 4'd0);
        serve(L3);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
